// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Two requesters share one combinational ALU, one op in flight.
//            Define ALU_ARB_ROUND_ROBIN_EN for round-robin tie breaking.
// Revision : 1.0
// ============================================================================
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_op1_i,
  input  logic [DATA_W-1:0] req0_op2_i,
  input  logic [CTRL_W-1:0] req0_ctrl_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_op1_i,
  input  logic [DATA_W-1:0] req1_op2_i,
  input  logic [CTRL_W-1:0] req1_ctrl_i,
  output logic              rsp0_valid_o,
  output logic [DATA_W-1:0] rsp0_data_o,
  input  logic              rsp0_ready_i,
  output logic              rsp1_valid_o,
  output logic [DATA_W-1:0] rsp1_data_o,
  input  logic              rsp1_ready_i,
  output logic [DATA_W-1:0] alu_data1_o,
  output logic [DATA_W-1:0] alu_data2_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_data_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] result_q;
  logic              gnt_q;
  logic              rsp0_valid_q;
  logic              rsp1_valid_q;
  logic              busy_q;
  logic              gnt_d;
  logic              idle;
  logic              any_valid;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic              last_q;

  // A tie goes to whoever did not win the previous transfer.
  always_comb begin
    gnt_d = req1_valid_i;
    if (req0_valid_i && req1_valid_i) begin
      gnt_d = ~last_q;
    end
  end
`else
  always_comb begin
    gnt_d = ~req0_valid_i & req1_valid_i;
  end
`endif

  assign idle         = (state_q == IDLE) && !rst_i;
  assign any_valid    = req0_valid_i | req1_valid_i;
  assign req0_ready_o = idle && req0_valid_i && !gnt_d;
  assign req1_ready_o = idle && req1_valid_i && gnt_d;

  assign rsp0_valid_o = rsp0_valid_q && !rst_i;
  assign rsp1_valid_o = rsp1_valid_q && !rst_i;
  assign rsp0_data_o  = rsp0_valid_o ? result_q : '0;
  assign rsp1_data_o  = rsp1_valid_o ? result_q : '0;
  assign busy_o       = busy_q && !rst_i;

  // The shared ALU only sees operands while this block owns it.
  assign alu_data1_o  = (state_q == EXEC) ? op1_q  : '0;
  assign alu_data2_o  = (state_q == EXEC) ? op2_q  : '0;
  assign alu_ctrl_o   = (state_q == EXEC) ? ctrl_q : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      op1_q        <= '0;
      op2_q        <= '0;
      ctrl_q       <= '0;
      result_q     <= '0;
      gnt_q        <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_q       <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            op1_q   <= gnt_d ? req1_op1_i  : req0_op1_i;
            op2_q   <= gnt_d ? req1_op2_i  : req0_op2_i;
            ctrl_q  <= gnt_d ? req1_ctrl_i : req0_ctrl_i;
            gnt_q   <= gnt_d;
            busy_q  <= 1'b1;
            state_q <= EXEC;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last_q  <= gnt_d;
`endif
          end
        end
        EXEC: begin
          result_q     <= alu_data_i;
          rsp0_valid_q <= ~gnt_q;
          rsp1_valid_q <= gnt_q;
          state_q      <= RESP;
        end
        RESP: begin
          if (gnt_q ? rsp1_ready_i : rsp0_ready_i) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          rsp0_valid_q <= 1'b0;
          rsp1_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Scoreboard bench for alu_arbiter with a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_alu_arbiter;
  localparam int DW = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          v0 = 0, v1 = 0, rr0 = 0, rr1 = 0;
  logic [DW-1:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [CW-1:0] c0 = 0, c1 = 0;
  logic          rdy0, rdy1, rv0, rv1, busy;
  logic [DW-1:0] rd0, rd1, alu_d1, alu_d2, alu_res;
  logic [CW-1:0] alu_c;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_f(input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      3'b011:  return a + b;
      3'b100:  return a - b;
      3'b101:  return a * b;
      3'b110:  return a << b[4:0];
      default: return (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  assign alu_res = alu_f(alu_c, alu_d1, alu_d2);

  alu_arbiter #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_op1_i(a0), .req0_op2_i(b0), .req0_ctrl_i(c0),
    .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_op1_i(a1), .req1_op2_i(b1), .req1_ctrl_i(c1),
    .rsp0_valid_o(rv0), .rsp0_data_o(rd0), .rsp0_ready_i(rr0),
    .rsp1_valid_o(rv1), .rsp1_data_o(rd1), .rsp1_ready_i(rr1),
    .alu_data1_o(alu_d1), .alu_data2_o(alu_d2), .alu_ctrl_o(alu_c),
    .alu_data_i(alu_res), .busy_o(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit            id;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb_q[$];

  // Transaction-level model: free/busy, cycles since the accepted op, owner.
  bit            m_free = 1;
  int            m_cnt  = 0;
  bit            m_id   = 0;
  bit            m_last = 1;
  logic [DW-1:0] m_a = 0, m_b = 0, m_res = 0;
  logic [CW-1:0] m_c = 0;

  task automatic cycle(input bit r, input bit iv0, input bit iv1,
                       input logic [DW-1:0] ia0, input logic [DW-1:0] ib0, input logic [CW-1:0] ic0,
                       input logic [DW-1:0] ia1, input logic [DW-1:0] ib1, input logic [CW-1:0] ic1,
                       input bit ir0, input bit ir1);
    bit w, e_rdy0, e_rdy1, e_rv0, e_rv1, e_exec;
    @(negedge clk);
    rst = r; v0 = iv0; v1 = iv1; a0 = ia0; b0 = ib0; c0 = ic0;
    a1 = ia1; b1 = ib1; c1 = ic1; rr0 = ir0; rr1 = ir1;
    #1;
    if (iv0 && iv1) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
      w = !m_last;
`else
      w = 1'b0;
`endif
    end else begin
      w = iv1;
    end
    e_rdy0 = !r && m_free && iv0 && !w;
    e_rdy1 = !r && m_free && iv1 && w;
    e_rv0  = !r && !m_free && m_cnt >= 1 && !m_id;
    e_rv1  = !r && !m_free && m_cnt >= 1 && m_id;
    e_exec = !m_free && m_cnt == 0;
    chk("ready0", rdy0, e_rdy0);
    chk("ready1", rdy1, e_rdy1);
    chk("rsp0_valid", rv0, e_rv0);
    chk("rsp1_valid", rv1, e_rv1);
    chk("rsp0_data", rd0, e_rv0 ? m_res : '0);
    chk("rsp1_data", rd1, e_rv1 ? m_res : '0);
    chk("busy", busy, !r && !m_free);
    chk("alu_data1", alu_d1, e_exec ? m_a : '0);
    chk("alu_data2", alu_d2, e_exec ? m_b : '0);
    chk("alu_ctrl", alu_c, e_exec ? m_c : '0);
    @(posedge clk);
    if (r) begin
      m_free = 1; m_last = 1; m_cnt = 0;
      sb_q.delete();
    end else if (m_free) begin
      if (iv0 || iv1) begin
        m_free = 0; m_cnt = 0; m_id = w; m_last = w;
        m_a = w ? ia1 : ia0; m_b = w ? ib1 : ib0; m_c = w ? ic1 : ic0;
        m_res = alu_f(m_c, m_a, m_b);
        sb_q.push_back('{w, m_res});
      end
    end else if (m_cnt == 0) begin
      m_cnt = 1;
    end else if (m_id ? ir1 : ir0) begin
      m_free = 1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
  endtask

  // Monitor: every consumed response must match the oldest accepted op.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if ((rv0 && rr0) || (rv1 && rr1)) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_id", rv1, e.id);
          chk("rsp_result", rv1 ? rd1 : rd0, e.data);
        end
      end
    end
  end

  initial begin
    // Reset held with requests present: nothing may handshake.
    cycle(1, 1, 1, 1, 2, 3, 4, 5, 3, 1, 1);
    cycle(1, 1, 0, 1, 2, 3, 4, 5, 3, 1, 1);
    idle_cycles(2);

    // Single ADD from requester 0.
    cycle(0, 1, 0, 7, 5, 3'b011, 0, 0, 0, 1, 1);
    idle_cycles(4);

    // Both requesting continuously.
    for (int i = 0; i < 12; i++) cycle(0, 1, 1, 9, 4, 3'b100, 3, 6, 3'b101, 1, 1);
    idle_cycles(3);

    // Requester 1 result held while req0 keeps asking.
    cycle(0, 0, 1, 0, 0, 0, 32'hF0, 32'h3C, 3'b000, 1, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, 1, 1, 3'b011, 32'h55, 32'h55, 3'b001, 1, 0);
    cycle(0, 1, 0, 1, 1, 3'b011, 0, 0, 0, 1, 1);
    idle_cycles(4);

    // Reset while EXEC discards the op; the next op is unaffected.
    cycle(0, 1, 0, 1, 1, 3'b011, 0, 0, 0, 1, 1);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle_cycles(3);
    cycle(0, 1, 0, 2, 3, 3'b011, 0, 0, 0, 1, 1);
    idle_cycles(4);

    // Wrap-around add.
    cycle(0, 1, 0, 32'hFFFF_FFFF, 32'h1, 3'b011, 0, 0, 0, 1, 1);
    idle_cycles(4);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom, $urandom, $urandom_range(0, 7),
            $urandom, $urandom, $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 1));
    end
    idle_cycles(6);
    chk("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width.
REQ-002 Parameter: CTRL_W, 3, ALU control code width.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset; synchronous and active-high.
REQ-005 reqN_valid_i  input  1  (N=0,1) requester N presents an operation.
REQ-006 reqN_ready_o  output  1  operation of requester N is accepted this cycle.
REQ-007 reqN_op1_i, reqN_op2_i  input  DATA_W  operands of requester N.
REQ-008 reqN_ctrl_i  input  CTRL_W  ALU control code of requester N.
REQ-009 rspN_valid_o  output  1  result for requester N is available.
REQ-010 rspN_data_o  output  DATA_W  result for requester N.
REQ-011 rspN_ready_i  input  1  requester N consumes its result.
REQ-012 alu_data1_o, alu_data2_o  output  DATA_W  operands to the shared ALU.
REQ-013 alu_ctrl_o  output  CTRL_W  control code to the shared ALU.
REQ-014 alu_data_i  input  DATA_W  combinational ALU result.
REQ-015 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, EXEC, RESP SHALL be the only states.
REQ-017 IDLE: grant = arbitration winner among asserted reqN_valid_i; reqN_ready_o = 1 for the winner only, combinationally; all ready low outside IDLE.
REQ-018 Transfer (valid && ready) SHALL latch op1, op2, ctrl and grant id into internal registers and move IDLE -> EXEC.
REQ-019 No valid in IDLE: remain IDLE, no ready asserted.
REQ-020 EXEC: alu_data1_o/alu_data2_o/alu_ctrl_o driven from latched registers; alu_data_i captured into result register at the clock edge; EXEC -> RESP unconditionally.
REQ-021 Outside EXEC, alu_data1_o, alu_data2_o, alu_ctrl_o SHALL be all zero.
REQ-022 RESP: rspG_valid_o = 1 for granted id G only; rspG_data_o = result register; other rsp valid low.
REQ-023 RESP holds (valid and data stable) until rspG_ready_i = 1; that cycle RESP -> IDLE.
REQ-024 Latency: transfer at edge N -> rsp valid from cycle N+2; minimum 3 cycles per operation; one operation in flight max.
REQ-025 rspN_data_o for the non-granted requester SHALL read zero.
REQ-026 Requester inputs SHALL be ignored outside IDLE; changes after transfer do not affect the result.
REQ-027 Results wrap modulo 2^DATA_W; arbiter adds no arithmetic.
REQ-028 Ready of the non-granted requester SHALL not depend on its own valid (no combinational loop from valid to own ready beyond arbitration).

Reset
REQ-029 rst_i high at an edge: state -> IDLE, latched operands/ctrl/result -> 0, grant id -> 0, last-grant pointer -> 1.
REQ-030 Reset mid-EXEC or mid-RESP SHALL discard the operation; rsp valids low in the cycle after reset; no response ever issued for it.
REQ-031 While rst_i high, all ready/valid outputs and busy_o SHALL be 0.

Configuration
REQ-032 Macro ALU_ARB_ROUND_ROBIN_EN defined: tie (both valid in IDLE) won by requester not granted last; last-grant pointer updated on each transfer.
REQ-033 Macro undefined: fixed priority, requester 0 always wins ties; last-grant pointer absent; single-requester behaviour identical to defined case.

Verification
REQ-034 req0 only, op1=7, op2=5, ctrl=3'b011, rsp0_ready=1 -> ready0 cycle 0, rsp0_valid cycle 2 with data 12, busy low cycle 3.
REQ-035 Both valid continuously, req0 ctrl=3'b100 (9,4), req1 ctrl=3'b101 (3,6), ROUND_ROBIN_EN -> grants 0,1,0,1; results 5,18 alternating; undefined -> only req0 granted.
REQ-036 rsp1_ready held low 4 cycles, req1 op ctrl=3'b000 (0xF0,0x3C) -> rsp1_valid high and data 0x30 stable all 4 cycles; ready0 low throughout despite req0_valid.
REQ-037 rst_i asserted in EXEC for op 1+1 -> no rsp valid ever for it; next req0 (2,3,ADD) after reset returns 5 with latency 2.
REQ-038 ADD 0xFFFFFFFF+1 -> result 0x00000000; ALU outputs zero in IDLE and RESP cycles.
